// File: rtl/pc_pkg.sv
// Shared constants and types for the program-counter sequencer.
// Optional return stack is enabled by defining PC_RETURN_STACK_EN.
package pc_pkg;

  localparam int unsigned DEF_PC_WIDTH    = 16;
  localparam int unsigned DEF_STEP        = 1;
  localparam int unsigned DEF_RESET_VEC   = 0;
  localparam int unsigned DEF_STACK_DEPTH = 4;

  // Source selected for the next program counter value
  typedef enum logic [2:0] {
    HOLD   = 3'd0,
    INC    = 3'd1,
    LOAD   = 3'd2,
    BRANCH = 3'd3,
    CALL   = 3'd4,
    RET    = 3'd5
  } pc_src_e;

endpackage

// File: rtl/pc_ret_stack.sv
// LIFO return-address stack with registered occupancy flags.
// Entries are not reset; only the count is, which discards pending addresses.
module pc_ret_stack #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             push_data,
  output logic [WIDTH-1:0]             top,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  // Occupancy count and flags; overflowing push / underflowing pop are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else if (push && !full) begin
      count <= count + CW'(1);
      empty <= 1'b0;
      full  <= (count == CW'(DEPTH - 1));
    end else if (pop && !empty) begin
      count <= count - CW'(1);
      full  <= 1'b0;
      empty <= (count == CW'(1));
    end
  end

  // Entry storage, written at the current count
  always_ff @(posedge clk) begin
    if (!reset && push && !full) begin
      mem[count[AW-1:0]] <= push_data;
    end
  end

  assign top = mem[AW'(count - CW'(1))];

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with increment, absolute load, relative branch and
// (when PC_RETURN_STACK_EN is defined) call/return via a return stack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned          PC_WIDTH     = DEF_PC_WIDTH,
  parameter int unsigned          STEP         = DEF_STEP,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = PC_WIDTH'(DEF_RESET_VEC),
  parameter int unsigned          STACK_DEPTH  = DEF_STACK_DEPTH
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Stall,
  input  logic                PCWrite,
  input  logic                PCRead,
  input  logic                Branch,
  input  logic                Call,
  input  logic                Ret,
  input  logic [PC_WIDTH-1:0] D,
  input  logic [PC_WIDTH-1:0] Offset,
  output logic [PC_WIDTH-1:0] PCResult,
  output logic                StackEmpty,
  output logic                StackFull,
  output logic                StackErr
);

  pc_src_e             src;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] pc_next;

  assign pc_inc = PCResult + PC_WIDTH'(STEP);

`ifdef PC_RETURN_STACK_EN
  logic                               push;
  logic                               pop;
  logic                               err_set;
  logic [PC_WIDTH-1:0]                stk_top;
  logic [$clog2(STACK_DEPTH+1)-1:0]   stk_count;
  logic                               stk_full;
  logic                               stk_empty;
  logic                               unused_count;

  pc_ret_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (Clk),
    .reset     (Reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (stk_top),
    .count     (stk_count),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  assign unused_count = ^stk_count;
  assign StackEmpty   = stk_empty;
  assign StackFull    = stk_full;

  // Priority decode: Stall > Ret > Call > PCRead > Branch > PCWrite
  always_comb begin
    src     = HOLD;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    if (Stall) begin
      src = HOLD;
    end else if (Ret) begin
      if (stk_empty) begin
        err_set = 1'b1;
      end else begin
        src = RET;
        pop = 1'b1;
      end
    end else if (Call) begin
      src = CALL;
      if (stk_full) err_set = 1'b1;
      else          push    = 1'b1;
    end else if (PCRead) begin
      src = LOAD;
    end else if (Branch) begin
      src = BRANCH;
    end else if (PCWrite) begin
      src = INC;
    end
  end

  // Sticky overflow/underflow flag, cleared only by reset
  always_ff @(posedge Clk) begin
    if (Reset)        StackErr <= 1'b0;
    else if (err_set) StackErr <= 1'b1;
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^{Ret, 32'(STACK_DEPTH)};
  assign StackEmpty = 1'b1;
  assign StackFull  = 1'b0;
  assign StackErr   = 1'b0;

  // Priority decode without a stack: Call acts as a plain load, Ret is ignored
  always_comb begin
    src = HOLD;
    if (Stall) begin
      src = HOLD;
    end else if (Call || PCRead) begin
      src = LOAD;
    end else if (Branch) begin
      src = BRANCH;
    end else if (PCWrite) begin
      src = INC;
    end
  end
`endif

  // Next-PC selection
  always_comb begin
    pc_next = PCResult;
    case (src)
      INC:     pc_next = pc_inc;
      LOAD:    pc_next = D;
      BRANCH:  pc_next = PCResult + Offset;
      CALL:    pc_next = D;
`ifdef PC_RETURN_STACK_EN
      RET:     pc_next = stk_top;
`endif
      default: pc_next = PCResult;
    endcase
  end

  // Program counter register; reset overrides stall
  always_ff @(posedge Clk) begin
    if (Reset) PCResult <= RESET_VECTOR;
    else       PCResult <= pc_next;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default parameters).
// Covers the return-stack build when PC_RETURN_STACK_EN is defined.
module tb_pc_sequencer;

  logic        Clk = 1'b0;
  logic        Reset, Stall, PCWrite, PCRead, Branch, Call, Ret;
  logic [15:0] D, Offset;
  logic [15:0] PCResult;
  logic        StackEmpty, StackFull, StackErr;

  int passed = 0;
  int total  = 0;

  pc_sequencer dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Stall      (Stall),
    .PCWrite    (PCWrite),
    .PCRead     (PCRead),
    .Branch     (Branch),
    .Call       (Call),
    .Ret        (Ret),
    .D          (D),
    .Offset     (Offset),
    .PCResult   (PCResult),
    .StackEmpty (StackEmpty),
    .StackFull  (StackFull),
    .StackErr   (StackErr)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic flags(input string tag, input logic e, input logic f, input logic r);
    check({tag, "_empty"}, 16'(StackEmpty), 16'(e));
    check({tag, "_full"},  16'(StackFull),  16'(f));
    check({tag, "_err"},   16'(StackErr),   16'(r));
  endtask

  // Apply one cycle of requests: {rst, stall, ret, call, rd, br, wr}
  task automatic cyc(input logic [6:0] req, input logic [15:0] d, input logic [15:0] off);
    {Reset, Stall, Ret, Call, PCRead, Branch, PCWrite} = req;
    D      = d;
    Offset = off;
    @(posedge Clk);
    #1;
    {Reset, Stall, Ret, Call, PCRead, Branch, PCWrite} = 7'b0;
  endtask

  localparam logic [6:0] R_RST = 7'b1000000;
  localparam logic [6:0] R_STL = 7'b0100000;
  localparam logic [6:0] R_RET = 7'b0010000;
  localparam logic [6:0] R_CAL = 7'b0001000;
  localparam logic [6:0] R_RD  = 7'b0000100;
  localparam logic [6:0] R_BR  = 7'b0000010;
  localparam logic [6:0] R_WR  = 7'b0000001;
  localparam logic [6:0] R_NOP = 7'b0000000;

  initial begin
    {Reset, Stall, Ret, Call, PCRead, Branch, PCWrite} = 7'b0;
    D = '0;
    Offset = '0;
    #1;

    // Reset state
    cyc(R_RST, 16'h0000, 16'h0000);
    check("reset_pc", PCResult, 16'h0000);
    flags("reset", 1'b1, 1'b0, 1'b0);

    // Sequential increment and wrap
    cyc(R_WR, 16'h0, 16'h0); check("inc1", PCResult, 16'h0001);
    cyc(R_WR, 16'h0, 16'h0); check("inc2", PCResult, 16'h0002);
    cyc(R_WR, 16'h0, 16'h0); check("inc3", PCResult, 16'h0003);
    cyc(R_RD, 16'hFFFF, 16'h0); check("load_ffff", PCResult, 16'hFFFF);
    cyc(R_WR, 16'h0, 16'h0); check("inc_wrap", PCResult, 16'h0000);

    // Branches and priority over lower requests
    cyc(R_RD, 16'h0010, 16'h0); check("load_10", PCResult, 16'h0010);
    cyc(R_BR, 16'h0, 16'hFFF8); check("branch_neg", PCResult, 16'h0008);
    cyc(R_BR | R_RD, 16'h0100, 16'h0004); check("read_over_branch", PCResult, 16'h0100);
    cyc(R_BR, 16'h0, 16'h0005); check("branch_pos", PCResult, 16'h0105);
    cyc(R_BR | R_WR, 16'h0, 16'h0002); check("branch_over_inc", PCResult, 16'h0107);
    cyc(R_NOP, 16'h0, 16'h0); check("hold", PCResult, 16'h0107);
    cyc(R_RD, 16'h0002, 16'h0); check("load_2", PCResult, 16'h0002);
    cyc(R_BR, 16'h0, 16'hFFFC); check("branch_wrap_below0", PCResult, 16'hFFFE);

`ifdef PC_RETURN_STACK_EN
    // Single call / return
    cyc(R_RD, 16'h0020, 16'h0); check("load_20", PCResult, 16'h0020);
    cyc(R_CAL, 16'h0200, 16'h0); check("call1", PCResult, 16'h0200);
    flags("call1", 1'b0, 1'b0, 1'b0);
    cyc(R_RET, 16'h0, 16'h0); check("ret1", PCResult, 16'h0021);
    flags("ret1", 1'b1, 1'b0, 1'b0);

    // Nested calls up to overflow
    cyc(R_RD, 16'h1000, 16'h0);
    cyc(R_CAL | R_RD, 16'h2000, 16'h0); check("ncall1", PCResult, 16'h2000);
    cyc(R_CAL, 16'h3000, 16'h0); check("ncall2", PCResult, 16'h3000);
    cyc(R_CAL, 16'h4000, 16'h0); check("ncall3", PCResult, 16'h4000);
    flags("ncall3", 1'b0, 1'b0, 1'b0);
    cyc(R_CAL, 16'h5000, 16'h0); check("ncall4", PCResult, 16'h5000);
    flags("ncall4", 1'b0, 1'b1, 1'b0);
    cyc(R_CAL, 16'h6000, 16'h0); check("ncall5", PCResult, 16'h6000);
    flags("ncall5", 1'b0, 1'b1, 1'b1);

    // LIFO unwind, then underflow holds PC
    cyc(R_RET | R_CAL, 16'h7000, 16'h0); check("nret1", PCResult, 16'h4001);
    flags("nret1", 1'b0, 1'b0, 1'b1);
    cyc(R_RET, 16'h0, 16'h0); check("nret2", PCResult, 16'h3001);
    cyc(R_RET, 16'h0, 16'h0); check("nret3", PCResult, 16'h2001);
    cyc(R_RET, 16'h0, 16'h0); check("nret4", PCResult, 16'h1001);
    flags("nret4", 1'b1, 1'b0, 1'b1);
    cyc(R_RET | R_WR, 16'h0, 16'h0); check("nret5_hold", PCResult, 16'h1001);
    flags("nret5", 1'b1, 1'b0, 1'b1);

    // Stall freezes PC and stack
    cyc(R_RST, 16'h0, 16'h0);
    cyc(R_RD, 16'h0050, 16'h0);
    cyc(R_CAL, 16'h0300, 16'h0); check("scall", PCResult, 16'h0300);
    cyc(R_STL | R_WR | R_CAL, 16'h0400, 16'h0); check("stall1", PCResult, 16'h0300);
    cyc(R_STL | R_WR | R_CAL, 16'h0400, 16'h0); check("stall2", PCResult, 16'h0300);
    flags("stall", 1'b0, 1'b0, 1'b0);
    cyc(R_STL | R_RET, 16'h0, 16'h0); check("stall_ret", PCResult, 16'h0300);
    cyc(R_RET, 16'h0, 16'h0); check("ret_after_stall", PCResult, 16'h0051);
    flags("ret_after_stall", 1'b1, 1'b0, 1'b0);

    // Reset overrides stall and discards pending returns
    cyc(R_CAL, 16'h0400, 16'h0); check("call_pre_rst", PCResult, 16'h0400);
    cyc(R_RST | R_STL, 16'h0, 16'h0); check("stall_reset", PCResult, 16'h0000);
    flags("stall_reset", 1'b1, 1'b0, 1'b0);
    cyc(R_RET, 16'h0, 16'h0); check("ret_after_rst", PCResult, 16'h0000);
    flags("ret_after_rst", 1'b1, 1'b0, 1'b1);
`else
    // Without the stack: Call is a load, Ret is ignored, flags tied
    cyc(R_CAL, 16'h0300, 16'h0); check("call_as_load", PCResult, 16'h0300);
    flags("call_as_load", 1'b1, 1'b0, 1'b0);
    cyc(R_RET, 16'h0, 16'h0); check("ret_ignored", PCResult, 16'h0300);
    flags("ret_ignored", 1'b1, 1'b0, 1'b0);
    cyc(R_CAL | R_BR, 16'h0440, 16'h0010); check("call_over_branch", PCResult, 16'h0440);

    // Stall freezes PC; reset overrides stall
    cyc(R_STL | R_WR | R_CAL, 16'h0400, 16'h0); check("stall1", PCResult, 16'h0440);
    cyc(R_STL | R_WR | R_CAL, 16'h0400, 16'h0); check("stall2", PCResult, 16'h0440);
    cyc(R_WR, 16'h0, 16'h0); check("inc_after_stall", PCResult, 16'h0441);
    cyc(R_RST | R_STL, 16'h0, 16'h0); check("stall_reset", PCResult, 16'h0000);
    flags("stall_reset", 1'b1, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_WIDTH, default 16, SHALL set the width of the program counter, D and Offset.
REQ-002 Parameter STEP, default 1, SHALL be the increment added on PCWrite.
REQ-003 Parameter RESET_VECTOR, default 0, SHALL be the PCResult value after reset.
REQ-004 Parameter STACK_DEPTH, default 4, SHALL be the return-stack entry count, power of two, >=2.
REQ-005 Clk  in  1  single clock; all state updates on posedge Clk.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 Stall  in  1  holds all state when high.
REQ-008 PCWrite  in  1  sequential increment request.
REQ-009 PCRead  in  1  absolute load of D request.
REQ-010 Branch  in  1  relative branch request using Offset.
REQ-011 Call  in  1  push return address, then load D.
REQ-012 Ret  in  1  pop return address into PC.
REQ-013 D  in  PC_WIDTH  absolute target address.
REQ-014 Offset  in  PC_WIDTH  two's-complement branch displacement.
REQ-015 PCResult  out  PC_WIDTH  current program counter, registered.
REQ-016 StackEmpty / StackFull  out  1 each  return-stack occupancy flags, registered.
REQ-017 StackErr  out  1  sticky flag for overflow or underflow.

Function
REQ-018 Per-cycle priority SHALL be: Reset > Stall > Ret > Call > PCRead > Branch > PCWrite > hold.
REQ-019 PCWrite SHALL set PCResult to PCResult+STEP, modulo 2^PC_WIDTH, one cycle after assertion.
REQ-020 PCRead SHALL set PCResult to D on the next edge.
REQ-021 Branch SHALL set PCResult to PCResult+Offset, modulo 2^PC_WIDTH; a negative Offset wraps below 0.
REQ-022 Call SHALL push PCResult+STEP (wrapped) and set PCResult to D in the same edge.
REQ-023 Ret SHALL set PCResult to the top entry and pop it in the same edge.
REQ-024 Call while StackFull SHALL still load D, SHALL drop the push, and SHALL set StackErr.
REQ-025 Ret while StackEmpty SHALL hold PCResult and set StackErr.
REQ-026 The stack pointer SHALL count 0..STACK_DEPTH; StackEmpty is (count==0) and StackFull is (count==STACK_DEPTH).
REQ-027 When Stall is high, PCResult, the stack contents, the count and StackErr SHALL hold regardless of other requests.
REQ-028 Lower-priority requests asserted together with a higher-priority request SHALL be ignored, with no side effects.

Reset
REQ-029 Reset SHALL set PCResult=RESET_VECTOR, count=0, StackEmpty=1, StackFull=0 and StackErr=0 on the next posedge, overriding Stall.
REQ-030 Stack entry contents SHALL need no reset; Reset asserted mid-sequence SHALL discard all pending return addresses.

Configuration
REQ-031 With macro PC_RETURN_STACK_EN defined, the return stack and REQ-022..REQ-026 SHALL be present.
REQ-032 Without PC_RETURN_STACK_EN, no stack storage SHALL be built: Call SHALL behave exactly as PCRead, Ret SHALL be ignored, StackEmpty SHALL tie to 1, and StackFull and StackErr SHALL tie to 0.

Structure
REQ-033 Package pc_pkg SHALL hold the default PC_WIDTH, STEP, RESET_VECTOR and STACK_DEPTH constants, plus the next-PC source enumeration (HOLD, INC, LOAD, BRANCH, CALL, RET).
REQ-034 The return stack SHALL be the sub-module pc_ret_stack (push, pop, top, count, full, empty); the top level holds the PC register and the priority decode.

Verification
REQ-035 Reset, then PCWrite for 3 cycles -> PCResult 0,1,2,3; with PCResult=16'hFFFF, PCWrite -> 16'h0000.
REQ-036 PCResult=16'h0010, Branch with Offset=16'hFFF8 -> 16'h0008; Branch and PCRead together with D=16'h0100 -> 16'h0100.
REQ-037 PCResult=16'h0020, Call with D=16'h0200 -> PCResult 16'h0200 and StackEmpty=0; then Ret -> 16'h0021 and StackEmpty=1.
REQ-038 Five nested Calls with STACK_DEPTH=4 -> StackFull=1 after the fourth; the fifth loads D and sets StackErr=1; four Rets unwind in LIFO order; the fifth Ret holds PCResult.
REQ-039 Stall held high with PCWrite and Call asserted for 2 cycles -> PCResult and count unchanged; Stall plus Reset -> RESET_VECTOR.
REQ-040 Build without PC_RETURN_STACK_EN: Call with D=16'h0300 -> 16'h0300 and StackEmpty stays 1; Ret -> PCResult holds.
